axi_window_ctl: RTL

AXI4-Lite register responder that owns the 64-bit window base address consumed by the AXI-MM sliding-window translator. Host software stages a new base in two 32-bit halves, and the block commits it atomically on the high-half write. The result drives `window_addr`. The block sits on the control interconnect, beside the data-path window translator, in the same clock domain.

---
 rtl/axi_window_ctl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/axi_window_ctl.sv
// AXI4-Lite responder holding the committed 64-bit window base for the sliding-window translator.
// Optional macro WINDOW_QUIESCE_EN defers commits until datapath_idle is seen.
module axi_window_ctl #(
  parameter int unsigned AW    = 64,
  parameter int unsigned ALIGN = 12
) (
  input  logic          clk,
  input  logic          resetn,
  output logic [AW-1:0] window_addr,
  output logic          window_update,
  input  logic          datapath_idle,
  input  logic [7:0]    S_AXI_AWADDR,
  input  logic          S_AXI_AWVALID,
  output logic          S_AXI_AWREADY,
  input  logic [31:0]   S_AXI_WDATA,
  input  logic [3:0]    S_AXI_WSTRB,
  input  logic          S_AXI_WVALID,
  output logic          S_AXI_WREADY,
  output logic [1:0]    S_AXI_BRESP,
  output logic          S_AXI_BVALID,
  input  logic          S_AXI_BREADY,
  input  logic [7:0]    S_AXI_ARADDR,
  input  logic          S_AXI_ARVALID,
  output logic          S_AXI_ARREADY,
  output logic [31:0]   S_AXI_RDATA,
  output logic [1:0]    S_AXI_RRESP,
  output logic          S_AXI_RVALID,
  input  logic          S_AXI_RREADY
);

  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;
  localparam logic [63:0] AW_MASK   = (AW >= 64) ? '1 : ((64'd1 << AW) - 64'd1);
  localparam logic [63:0] ADDR_MASK = AW_MASK & ~((64'd1 << ALIGN) - 64'd1);
  localparam logic [5:0]  IDX_STAGE_LO  = 6'd0;
  localparam logic [5:0]  IDX_STAGE_HI  = 6'd1;
  localparam logic [5:0]  IDX_ACTIVE_LO = 6'd2;
  localparam logic [5:0]  IDX_ACTIVE_HI = 6'd3;
  localparam logic [5:0]  IDX_STATUS    = 6'd4;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t        w_state, w_next;
  r_state_t        r_state, r_next;
  logic            out_of_rst;
  logic            wr_hs, rd_hs;
  logic [63:0]     stage, stage_nxt, active_addr;
  logic [DW-1:0]   wr_word, rd_word;
  logic            wr_err, rd_err, commit_wr;
  logic            pending;
  logic            unused_ok;

  assign unused_ok = ^{datapath_idle, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Address and data are only ever accepted together, never while in reset.
  assign wr_hs         = (w_state == W_IDLE) & S_AXI_AWVALID & S_AXI_WVALID & out_of_rst;
  assign S_AXI_AWREADY = wr_hs;
  assign S_AXI_WREADY  = wr_hs;
  assign S_AXI_BVALID  = (w_state == W_RESP);
  assign rd_hs         = S_AXI_ARREADY & S_AXI_ARVALID;
  assign S_AXI_RVALID  = (r_state == R_DATA);
  assign active_addr   = 64'(window_addr);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_state       <= W_IDLE;
      r_state       <= R_IDLE;
      out_of_rst    <= 1'b0;
      S_AXI_ARREADY <= 1'b0;
    end else begin
      w_state       <= w_next;
      r_state       <= r_next;
      out_of_rst    <= 1'b1;
      S_AXI_ARREADY <= (r_next == R_IDLE);
    end
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (wr_hs) w_next = W_RESP;
      W_RESP:  if (S_AXI_BREADY) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (rd_hs) r_next = R_DATA;
      R_DATA:  if (S_AXI_RREADY) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Byte-merge the write into the addressed staging half; unwritable bits stay 0.
  always_comb begin
    stage_nxt = stage;
    wr_err    = 1'b1;
    commit_wr = 1'b0;
    wr_word   = (S_AXI_AWADDR[7:2] == IDX_STAGE_HI) ? stage[63:32] : stage[31:0];
    for (int unsigned b = 0; b < SW; b++) begin
      if (S_AXI_WSTRB[b]) wr_word[8*b +: 8] = S_AXI_WDATA[8*b +: 8];
    end
    case (S_AXI_AWADDR[7:2])
      IDX_STAGE_LO: begin
        stage_nxt = {stage[63:32], wr_word} & ADDR_MASK;
        wr_err    = 1'b0;
      end
      IDX_STAGE_HI: begin
        stage_nxt = {wr_word, stage[31:0]} & ADDR_MASK;
        wr_err    = 1'b0;
        commit_wr = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_word = '0;
    rd_err  = 1'b0;
    case (S_AXI_ARADDR[7:2])
      IDX_STAGE_LO:  rd_word = stage[31:0];
      IDX_STAGE_HI:  rd_word = stage[63:32];
      IDX_ACTIVE_LO: rd_word = active_addr[31:0];
      IDX_ACTIVE_HI: rd_word = active_addr[63:32];
      IDX_STATUS:    rd_word = {31'd0, pending};
      default:       rd_err  = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      S_AXI_RDATA <= '0;
      S_AXI_RRESP <= RESP_OKAY;
    end else if (rd_hs) begin
      S_AXI_RDATA <= rd_word;
      S_AXI_RRESP <= rd_err ? RESP_SLVERR : RESP_OKAY;
    end
  end

`ifdef WINDOW_QUIESCE_EN
  // Commit waits for an idle data path; a new STAGE_HI write re-arms pending.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stage         <= '0;
      pending       <= 1'b0;
      window_addr   <= '0;
      window_update <= 1'b0;
      S_AXI_BRESP   <= RESP_OKAY;
    end else begin
      window_update <= 1'b0;
      if (wr_hs) begin
        S_AXI_BRESP <= wr_err ? RESP_SLVERR : RESP_OKAY;
        if (!wr_err) stage <= stage_nxt;
      end
      if (pending && datapath_idle) begin
        window_addr   <= AW'(stage);
        window_update <= 1'b1;
      end
      if (wr_hs && commit_wr)              pending <= 1'b1;
      else if (pending && datapath_idle)   pending <= 1'b0;
    end
  end
`else
  assign pending = 1'b0;

  // Commit lands on the STAGE_HI handshake edge, together with BVALID.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stage         <= '0;
      window_addr   <= '0;
      window_update <= 1'b0;
      S_AXI_BRESP   <= RESP_OKAY;
    end else begin
      window_update <= 1'b0;
      if (wr_hs) begin
        S_AXI_BRESP <= wr_err ? RESP_SLVERR : RESP_OKAY;
        if (!wr_err) stage <= stage_nxt;
        if (commit_wr) begin
          window_addr   <= AW'(stage_nxt);
          window_update <= 1'b1;
        end
      end
    end
  end
`endif

endmodule
